eth_pcs_rx_gearbox: RTL and testbench
=====================================

# eth_pcs_rx_gearbox

Receive-side 32-to-66 bit gearbox of the 10GBASE-R PCS. It takes raw 32-bit words from the SERDES every cycle and re-frames the bit stream into 66-bit blocks, delivered as a 2-bit sync header plus two 32-bit payload transfers. It sits between the SERDES RX interface and the descrambler/66b-64b decoder chain, and drives their `i_clk_en`, `i_grbx_hdr_valid` and `i_grbx_hdr` inputs. A one-bit slip input, driven by the block-lock FSM, shifts block alignment so the header boundary can be searched.

## Interface
Parameters
- No module parameters. Widths come from `cmn_params` / `eth_pcs_params`.
- `W_DATA`, 32: width of the SERDES word and of each payload transfer.
- `W_SYNC`, 2: sync header width.

Ports
- `i_clk`  in  1  RX recovered clock. Single clock domain.
- `i_reset`  in  1  Asynchronous, active-high reset.
- `i_rx_data`  in  W_DATA  SERDES word, valid every cycle. Bit 0 is the first bit received.
- `i_slip`  in  1  Request to drop one bit from the stream (block-lock slip).
- `o_clk_en`  out  1  Output transfer valid. Low for exactly one cycle in every 33 in steady state.
- `o_grbx_hdr_valid`  out  1  Asserted with the first transfer of each block.
- `o_grbx_hdr`  out  W_SYNC  Sync header. `o_grbx_hdr[0]` is the first received header bit. Held between headers.
- `o_grbx_data`  out  W_DATA  Payload transfer, LSB first.

## Operation
- **Bit buffer:** 66-bit LSB-first shift buffer `buf` with fill count `N` (0..66).
  - Each cycle `i_rx_data` is appended at bit position `N`, giving `avail = N + 32`.
  - Bits are consumed from bit 0.
- **Phase register:** `HDR` or `DATA`. Reset value is `HDR`.
- **`HDR` phase:**
  - `need = 34 + slip_pend`.
  - If `avail >= need`:
    - Drop `slip_pend` bits from the head.
    - Emit `hdr = next[1:0]` and `data = next[33:2]`, with `o_clk_en = 1` and `o_grbx_hdr_valid = 1`.
    - Consume `need` bits. Clear `slip_pend`. Phase becomes `DATA`.
  - Else (stall): `o_clk_en = 0`, `o_grbx_hdr_valid = 0`, nothing consumed, phase stays `HDR`.
- **`DATA` phase:**
  - `avail >= 32` always holds.
  - Emit `data = buf[31:0]` with `o_clk_en = 1` and `o_grbx_hdr_valid = 0`.
  - Consume 32 bits. Phase becomes `HDR`.
- **Fill count:** `N` falls by 2 per block. A stall occurs when `N < 2` (or `N < 3` with a slip pending). This gives 32 transfers and 16 headers per 33 input cycles.
- **Slip handling:**
  - `i_slip` is sampled at the clock edge and sets `slip_pend`. It applies only at a later `HDR` extraction, never in the same cycle.
  - `i_slip` while `slip_pend` is already set is ignored. A multi-cycle pulse therefore drops exactly one bit.
  - A slip arriving in `DATA` phase stays pending until the next `HDR` extraction.
- **Buffer bound:** `N` never exceeds 34 before append, so `avail <= 66`. Overflow is impossible by construction. A bench assertion checks `avail <= 66`.
- **No header checking:** headers are passed through unchecked. Invalid headers (00/11) are forwarded unchanged; the decoder handles them.
- **Reset (asynchronous, any time including mid-block):**
  - `N = 0`, phase = `HDR`, `slip_pend = 0`.
  - All outputs go to 0: `o_clk_en`, `o_grbx_hdr_valid`, `o_grbx_hdr`, `o_grbx_data`.
  - After release, the stream restarts from an empty buffer. There is no partial-block carry-over.

## Timing
- All outputs are registered.
- An input word sampled at edge *t* contributes to outputs visible after edge *t+1*.
- After reset release, the first cycle always stalls (`avail = 32`). The first header transfer is driven after the second input edge. From then on the steady-state pattern is H, D, H, D, …, with one stall every 33 cycles.
- Header and payload ordering:
  - `o_grbx_hdr_valid` is only ever high together with `o_clk_en`.
  - The `DATA` transfer of a block always immediately follows its `HDR` transfer; a stall never occurs between them.
- Slip latency: `i_slip` high at edge *t* shifts alignment in the first `HDR` extraction at edge *t+1* or later.

## Test plan
- **Aligned stream:** reset, then feed 16 blocks (headers alternating 2'b10 / 2'b01, payload = block index pattern) packed as 33 words. Required: first `o_clk_en` after the 2nd edge; 16 `o_grbx_hdr_valid` pulses; headers and payloads bit-exact; exactly one stall cycle.
- **Long-run rate:** 330 cycles of a continuous framed stream. Required: exactly 320 `o_clk_en` cycles and 160 headers; stall spacing exactly 33 cycles.
- **Slip search:** stream offset by +5 bits; pulse `i_slip` 5 times, each pulse ≥ 70 cycles apart. Required: after the 5th slip, all headers match and payload is bit-exact. Before that, headers are misaligned.
- **Long slip pulse:** hold `i_slip` high for 3 cycles. Required: exactly one bit dropped.
- **Slip at boundary:** slip pending when `N = 2`. Required: one stall cycle, then extraction of 35 bits; `avail` never exceeds 66.
- **Mid-block reset:** assert `i_reset` asynchronously between edges during a `DATA` transfer. Required: all outputs 0 immediately. After release, one stall, then clean restart aligned to the new first word.

Source files
------------

// File: rtl/eth_pcs_rx_gearbox.sv
// 32-to-66 bit receive gearbox: re-frames the SERDES bit stream into a sync header
// plus two 32-bit payload transfers, with a one-bit slip for block-lock search.
module eth_pcs_rx_gearbox (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_rx_data,
    input  logic        i_slip,
    output logic        o_clk_en,
    output logic        o_grbx_hdr_valid,
    output logic [1:0]  o_grbx_hdr,
    output logic [31:0] o_grbx_data,
    output logic        o_dbg_phase
);
    localparam int W_DATA = 32;
    localparam int W_SYNC = 2;

    typedef enum logic {
        PH_HDR  = 1'b0,
        PH_DATA = 1'b1
    } phase_t;

    phase_t      phase;
    logic [65:0] bit_buf;
    logic [6:0]  fill;
    logic        slip_pend;
    logic        slip_q;

    logic [6:0]  avail;
    logic [6:0]  need;
    logic [65:0] merged;
    logic [33:0] aligned;
    logic        slip_req;
    logic        extract;

    // Valid-only stream, no backpressure: o_clk_en marks a payload transfer in the
    // cycle it is high; o_grbx_hdr_valid is only high with o_clk_en and tags the
    // first transfer of a block, whose second transfer always follows next cycle.
    always_comb begin
        avail    = fill + 7'd32;
        need     = 7'd34 + {6'd0, slip_pend};
        merged   = bit_buf | ({34'd0, i_rx_data} << fill);
        aligned  = slip_pend ? merged[34:1] : merged[33:0];
        // Rising edge only, so a slip held for several cycles drops a single bit.
        slip_req = i_slip && !slip_q;
        extract  = (phase == PH_HDR) && (avail >= need);
    end

    assign o_dbg_phase = phase;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            phase            <= PH_HDR;
            bit_buf          <= '0;
            fill             <= '0;
            slip_pend        <= 1'b0;
            slip_q           <= 1'b0;
            o_clk_en         <= 1'b0;
            o_grbx_hdr_valid <= 1'b0;
            o_grbx_hdr       <= '0;
            o_grbx_data      <= '0;
        end else begin
            slip_q <= i_slip;
            if (phase == PH_DATA) begin
                o_clk_en         <= 1'b1;
                o_grbx_hdr_valid <= 1'b0;
                o_grbx_data      <= merged[W_DATA-1:0];
                bit_buf          <= merged >> W_DATA;
                fill             <= avail - 7'd32;
                slip_pend        <= slip_pend || slip_req;
                phase            <= PH_HDR;
            end else if (extract) begin
                o_clk_en         <= 1'b1;
                o_grbx_hdr_valid <= 1'b1;
                o_grbx_hdr       <= aligned[W_SYNC-1:0];
                o_grbx_data      <= aligned[33:2];
                bit_buf          <= merged >> need;
                fill             <= avail - need;
                // A slip arriving while one is being applied is ignored.
                slip_pend        <= slip_req && !slip_pend;
                phase            <= PH_DATA;
            end else begin
                o_clk_en         <= 1'b0;
                o_grbx_hdr_valid <= 1'b0;
                bit_buf          <= merged;
                fill             <= avail;
                slip_pend        <= slip_pend || slip_req;
            end
        end
    end
endmodule

// File: tb/tb_eth_pcs_rx_gearbox.sv
// Directed bench for eth_pcs_rx_gearbox: framed bit-stream generator, scoreboard of
// expected transfers, slip alignment search and asynchronous reset scenarios.
module tb_eth_pcs_rx_gearbox;
    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_rx_data;
    logic        i_slip;
    logic        o_clk_en;
    logic        o_grbx_hdr_valid;
    logic [1:0]  o_grbx_hdr;
    logic [31:0] o_grbx_data;
    logic        o_dbg_phase;

    eth_pcs_rx_gearbox dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_rx_data        (i_rx_data),
        .i_slip           (i_slip),
        .o_clk_en         (o_clk_en),
        .o_grbx_hdr_valid (o_grbx_hdr_valid),
        .o_grbx_hdr       (o_grbx_hdr),
        .o_grbx_data      (o_grbx_data),
        .o_dbg_phase      (o_dbg_phase)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- shared state ----------------
    int checks = 0;
    int failures = 0;
    logic        bitq[$];
    logic [34:0] exp_q[$];
    logic [15:0] blk_idx;

    int mode;          // 0 none, 1 scoreboard, 2 slip observation
    int slip_phase;    // 0 count aligned, 1 require aligned, 2 ignore
    int cyc, n_en, n_hdr, n_stall, first_en, last_stall;
    bit spacing_on;
    bit s_have, prev_valid;
    logic [1:0]  s_hdr;
    logic [31:0] s_lo;
    logic [15:0] prev_idx;
    int aligned_hits, blk_ok;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic push_block();
        logic [1:0]  h;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [65:0] blk;
        h   = blk_idx[0] ? 2'b01 : 2'b10;
        lo  = {16'hA55A, blk_idx};
        hi  = ~lo;
        blk = {hi, lo, h};
        for (int i = 0; i < 66; i++) bitq.push_back(blk[i]);
        exp_q.push_back({1'b1, h, lo});
        exp_q.push_back({1'b0, h, hi});
        blk_idx++;
    endtask

    task automatic step(input logic slip);
        logic [31:0] w;
        while (bitq.size() < 32) push_block();
        for (int i = 0; i < 32; i++) w[i] = bitq.pop_front();
        i_rx_data = w;
        i_slip    = slip;
        @(negedge i_clk);
    endtask

    task automatic do_reset(input logic [15:0] base, input int junk);
        i_reset = 1'b1;
        i_slip  = 1'b0;
        repeat (2) @(negedge i_clk);
        bitq.delete();
        exp_q.delete();
        blk_idx = base;
        for (int i = 0; i < junk; i++) bitq.push_back(1'($urandom_range(0, 1)));
        cyc = 0; n_en = 0; n_hdr = 0; n_stall = 0; first_en = 0; last_stall = 0;
        s_have = 0; prev_valid = 0; aligned_hits = 0; blk_ok = 0;
        #2 i_reset = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge i_clk) begin
        logic [34:0] e;
        bit ok;
        #1;
        if (!i_reset) begin
            cyc++;
            check("avail_bound", 64'(dut.avail <= 7'd66), 64'd1);
            if (o_grbx_hdr_valid) check("hv_implies_en", 64'(o_clk_en), 64'd1);
            if (o_clk_en) begin
                n_en++;
                if (o_grbx_hdr_valid) n_hdr++;
                if (first_en == 0) first_en = cyc;
                if (mode == 1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL sb_empty observed=transfer expected=none");
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_hv", 64'(o_grbx_hdr_valid), 64'(e[34]));
                        check("sb_hdr", 64'(o_grbx_hdr), 64'(e[33:32]));
                        check("sb_data", 64'(o_grbx_data), 64'(e[31:0]));
                    end
                end else if (mode == 2) begin
                    if (o_grbx_hdr_valid) begin
                        s_hdr  = o_grbx_hdr;
                        s_lo   = o_grbx_data;
                        s_have = 1;
                    end else if (s_have) begin
                        s_have = 0;
                        ok = (s_hdr == (s_lo[0] ? 2'b01 : 2'b10)) &&
                             (s_lo[31:16] == 16'hA55A) && (o_grbx_data == ~s_lo);
                        if (slip_phase == 0) begin
                            if (ok) aligned_hits++;
                        end else if (slip_phase == 1) begin
                            check("slip_block_aligned", 64'(ok), 64'd1);
                            if (prev_valid)
                                check("slip_block_seq", 64'(s_lo[15:0]), 64'(16'(prev_idx + 16'd1)));
                            prev_idx   = s_lo[15:0];
                            prev_valid = 1;
                            if (ok) blk_ok++;
                        end
                    end
                end
            end else begin
                n_stall++;
                if (spacing_on && last_stall != 0)
                    check("stall_spacing", 64'(cyc - last_stall), 64'd33);
                last_stall = cyc;
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] lo15;
        logic [31:0] hi15;
        bit found;
        mode = 0; slip_phase = 2; spacing_on = 0;
        i_reset = 1'b1; i_slip = 1'b0; i_rx_data = '0; blk_idx = '0;

        // Reset state
        @(negedge i_clk);
        check("rst_clk_en", 64'(o_clk_en), 64'd0);
        check("rst_hdr_valid", 64'(o_grbx_hdr_valid), 64'd0);
        check("rst_hdr", 64'(o_grbx_hdr), 64'd0);
        check("rst_data", 64'(o_grbx_data), 64'd0);
        check("rst_phase", 64'(o_dbg_phase), 64'd0);

        // Aligned stream: 16 blocks in 33 words
        mode = 1;
        do_reset(16'd0, 0);
        repeat (33) step(1'b0);
        check("aligned_first_en", 64'(first_en), 64'd2);
        check("aligned_n_en", 64'(n_en), 64'd32);
        check("aligned_n_hdr", 64'(n_hdr), 64'd16);
        check("aligned_n_stall", 64'(n_stall), 64'd1);

        // Long-run rate over 330 further cycles
        n_en = 0; n_hdr = 0; n_stall = 0; spacing_on = 1;
        repeat (330) step(1'b0);
        spacing_on = 0;
        check("rate_n_en", 64'(n_en), 64'd320);
        check("rate_n_hdr", 64'(n_hdr), 64'd160);
        check("rate_n_stall", 64'(n_stall), 64'd10);

        // Mid-block asynchronous reset during a DATA transfer
        found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            step(1'b0);
            if (o_clk_en && !o_grbx_hdr_valid) found = 1;
        end
        check("midrst_data_seen", 64'(found), 64'd1);
        #3 i_reset = 1'b1;
        #1;
        check("midrst_clk_en", 64'(o_clk_en), 64'd0);
        check("midrst_hdr_valid", 64'(o_grbx_hdr_valid), 64'd0);
        check("midrst_hdr", 64'(o_grbx_hdr), 64'd0);
        check("midrst_data", 64'(o_grbx_data), 64'd0);
        do_reset(16'd200, 0);
        repeat (40) step(1'b0);
        check("restart_first_en", 64'(first_en), 64'd2);
        check("restart_n_stall", 64'(n_stall), 64'd2);
        check("restart_n_en", 64'(n_en), 64'd38);
        check("restart_n_hdr", 64'(n_hdr), 64'd19);

        // Slip pending when N = 2: stall, then a 35-bit extraction
        mode = 0;
        do_reset(16'd0, 0);
        for (int k = 1; k <= 30; k++) step(1'b0);
        step(1'b1);
        step(1'b0);
        check("bnd_stall", 64'(o_clk_en), 64'd0);
        step(1'b0);
        lo15 = {16'hA55A, 16'd15};
        hi15 = ~lo15;
        check("bnd_hdr_valid", 64'(o_grbx_hdr_valid), 64'd1);
        check("bnd_hdr", 64'(o_grbx_hdr), 64'({lo15[0], 1'b0}));
        check("bnd_data", 64'(o_grbx_data), 64'({hi15[0], lo15[31:1]}));
        step(1'b0);
        check("bnd_data2_en", 64'(o_clk_en), 64'd1);
        check("bnd_data2", 64'(o_grbx_data), 64'({1'b0, hi15[31:1]}));

        // Long slip pulse: one junk bit, 3-cycle slip must drop exactly one bit
        mode = 2; slip_phase = 0;
        do_reset(16'd0, 1);
        repeat (40) step(1'b0);
        check("long_pre_misaligned", 64'(aligned_hits), 64'd0);
        slip_phase = 2;
        repeat (3) step(1'b1);
        repeat (6) step(1'b0);
        slip_phase = 1;
        repeat (100) step(1'b0);
        check("long_blocks_ok", 64'(blk_ok >= 40), 64'd1);

        // Slip search: five junk bits, five single slips 70+ cycles apart
        slip_phase = 0;
        do_reset(16'd0, 5);
        repeat (20) step(1'b0);
        for (int p = 0; p < 4; p++) begin
            step(1'b1);
            repeat (70) step(1'b0);
        end
        check("search_pre_misaligned", 64'(aligned_hits), 64'd0);
        slip_phase = 2;
        step(1'b1);
        repeat (6) step(1'b0);
        slip_phase = 1;
        repeat (100) step(1'b0);
        check("search_blocks_ok", 64'(blk_ok >= 40), 64'd1);

        mode = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
